csr_ext_arbiter: RTL
====================

Name: csr_ext_arbiter

Overview:
- Arbitrates the external CSR bus between two requesters: m0 (CPU core CSR unit) and m1 (debug/host port).
- Sequences each access as a bus transaction with a ready handshake.
- Performs set/clear as a read-modify-write.
- Enforces a timeout so that a non-responding CSR device can never hang either requester.

Parameters:
- TIMEOUT, 15, max cycles waiting for i_ext_ready in one bus phase before abort (1..255)
- CNT_W, 8, width of the timeout counter

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_req  in  1  m0 request; held high until o_m0_ack
- i_m0_op  in  2  00 read, 01 write, 10 set, 11 clear
- i_m0_addr  in  12  CSR address
- i_m0_wr_data  in  32  write data / set-clear mask
- o_m0_ack  out  1  one-cycle completion pulse
- o_m0_err  out  1  valid with ack; 1 = timeout
- o_m0_rd_data  out  32  old CSR value; valid with ack
- i_m1_req, i_m1_op, i_m1_addr, i_m1_wr_data, o_m1_ack, o_m1_err, o_m1_rd_data: same as m0, for m1
- o_ext_addr  out  12  device address
- o_ext_wr_data  out  32  device write data
- o_ext_rd  out  1  read strobe, held until ready
- o_ext_wr  out  1  write strobe, held until ready
- i_ext_rd_data  in  32  device read data, sampled when ready
- i_ext_ready  in  1  device completes current phase

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. All ext outputs and acks are registered/Moore.
- Reset (async, i_rst_n=0) forces:
  - state=IDLE
  - all strobes, acks and errs = 0
  - rd_data and ext address/data = 0
  - last_grant=1, so m0 wins the first contention
  - counter=0
- Reset mid-transaction aborts without ack; requesters must reissue.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - Latch grant id, op, addr, wr_data; update last_grant.
  - Next state is WRITE for op=01, otherwise READ.
- READ:
  - o_ext_rd=1, o_ext_addr=latched addr.
  - On i_ext_ready=1: latch i_ext_rd_data into rdata.
    - op=00 -> RESP.
    - op=10 -> WRITE with data = rdata | mask.
    - op=11 -> WRITE with data = rdata & ~mask.
- WRITE:
  - o_ext_wr=1, o_ext_wr_data = computed data (or latched wr_data for op=01).
  - On i_ext_ready=1 -> RESP.
- Timeout:
  - Counter clears on entry to READ/WRITE and increments each cycle ready=0.
  - When counter==TIMEOUT-1 with ready=0: abort to RESP with err=1, rd_data=0, no write phase.
  - ready takes priority over timeout in the same cycle.
- RESP:
  - Granted ack=1 for exactly one cycle; err and rd_data valid this cycle.
  - For write ops, rd_data = 0 (op=01) or the old value (set/clear).
  - Non-granted requester sees ack=0, and its rd_data/err hold previous values.
  - Next state is always IDLE.
- Requester rule: req must be low in the cycle after ack unless a new transaction is intended. A req still high in IDLE is a new request and is arbitrated normally, so round-robin alternates under continuous contention.
- Latency from req sampled in IDLE with zero-wait device:
  - read: ack 2 cycles later
  - write: ack 2 cycles later
  - set/clear: ack 3 cycles later
- Inputs of the non-granted requester are ignored; changes on the granted requester's inputs after grant are ignored.
- o_ext_rd and o_ext_wr are never high simultaneously, and both are 0 in IDLE and RESP.

Test Plan:
- m0 read addr 0x7C0, device ready immediately with 0xDEADBEEF -> o_ext_rd high 1 cycle; o_m0_ack 2 cycles after grant, rd_data=0xDEADBEEF, err=0.
- m1 set addr 0x300, mask 0x00000008, device returns 0x00001800, ready after 2 waits -> o_ext_wr_data=0x00001808; o_m1_rd_data=0x00001800; ack once.
- m0 clear, mask 0x0000FFFF, old value 0x12345678 -> write data 0x12340000.
- Both req continuous reads from reset -> grants m0, m1, m0, m1; each ack one cycle; no ack to the wrong port.
- m0 write, ready never asserted, TIMEOUT=15 -> o_ext_wr high 15 cycles, then ack with err=1, rd_data=0; next transaction proceeds normally.
- Assert i_rst_n=0 during WRITE -> strobes drop immediately, no ack; after release, m0 wins first contention.

Source files
------------

// File: rtl/csr_ext_arbiter.sv
// csr_ext_arbiter: two-master arbiter for the external CSR bus.
// m0 (core CSR unit) and m1 (debug/host) share one device port. Each access
// runs as READ and/or WRITE bus phases with a ready handshake. Set/clear ops
// are read-modify-write. A per-phase timeout aborts a phase whose device
// never answers, so neither requester can hang.
module csr_ext_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_req,
    input  logic [1:0]  i_m0_op,
    input  logic [11:0] i_m0_addr,
    input  logic [31:0] i_m0_wr_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_rd_data,

    input  logic        i_m1_req,
    input  logic [1:0]  i_m1_op,
    input  logic [11:0] i_m1_addr,
    input  logic [31:0] i_m1_wr_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_rd_data,

    output logic [11:0] o_ext_addr,
    output logic [31:0] o_ext_wr_data,
    output logic        o_ext_rd,
    output logic        o_ext_wr,
    input  logic [31:0] i_ext_rd_data,
    input  logic        i_ext_ready
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;

    // Last counter value of a phase; reaching it with no ready aborts.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_gnt;         // 0 = m0 owns the bus, 1 = m1
    logic             r_last_grant;  // winner of the previous arbitration
    logic [1:0]       r_op;
    logic [31:0]      r_mask;        // latched wr_data, used as set/clear mask
    logic [31:0]      r_rdata;       // old CSR value captured in READ
    logic [CNT_W-1:0] r_cnt;

    logic             r_ext_rd;
    logic             r_ext_wr;
    logic [11:0]      r_ext_addr;
    logic [31:0]      r_ext_wr_data;

    logic             r_m0_ack;
    logic             r_m0_err;
    logic [31:0]      r_m0_rd_data;
    logic             r_m1_ack;
    logic             r_m1_err;
    logic [31:0]      r_m1_rd_data;

    logic             w_any_req;
    logic             w_pick_m1;
    logic [1:0]       w_op;
    logic [11:0]      w_addr;
    logic [31:0]      w_wr_data;
    logic             w_timeout;
    logic [31:0]      w_rmw_data;
    logic             w_fin;
    logic             w_fin_err;
    logic [31:0]      w_fin_data;

    // Round-robin pick: a lone requester wins; on contention the master
    // that did not win last time gets the bus.
    always_comb begin
        w_any_req = i_m0_req | i_m1_req;
        w_pick_m1 = i_m1_req & (~i_m0_req | ~r_last_grant);
        w_op      = w_pick_m1 ? i_m1_op      : i_m0_op;
        w_addr    = w_pick_m1 ? i_m1_addr    : i_m0_addr;
        w_wr_data = w_pick_m1 ? i_m1_wr_data : i_m0_wr_data;
    end

    // Phase abort condition and the modified value for set/clear.
    always_comb begin
        w_timeout  = ~i_ext_ready & (r_cnt == TO_LAST);
        w_rmw_data = (r_op == OP_SET) ? (i_ext_rd_data | r_mask)
                                      : (i_ext_rd_data & ~r_mask);
    end

    // Decide whether the transaction finishes this cycle and with what
    // result. Ready wins over timeout when both occur in the same cycle.
    always_comb begin
        w_fin      = 1'b0;
        w_fin_err  = 1'b0;
        w_fin_data = '0;
        case (r_state)
            S_READ: begin
                if (i_ext_ready) begin
                    if (r_op == OP_RD) begin
                        w_fin      = 1'b1;
                        w_fin_data = i_ext_rd_data;
                    end
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            S_WRITE: begin
                if (i_ext_ready) begin
                    w_fin      = 1'b1;
                    w_fin_data = (r_op == OP_WR) ? 32'h0 : r_rdata;
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus sequencer: arbitration, phase strobes, timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_gnt         <= 1'b0;
            r_last_grant  <= 1'b1;
            r_op          <= OP_RD;
            r_mask        <= '0;
            r_rdata       <= '0;
            r_cnt         <= '0;
            r_ext_rd      <= 1'b0;
            r_ext_wr      <= 1'b0;
            r_ext_addr    <= '0;
            r_ext_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt        <= w_pick_m1;
                        r_last_grant <= w_pick_m1;
                        r_op         <= w_op;
                        r_mask       <= w_wr_data;
                        r_ext_addr   <= w_addr;
                        r_cnt        <= '0;
                        if (w_op == OP_WR) begin
                            r_state       <= S_WRITE;
                            r_ext_wr      <= 1'b1;
                            r_ext_wr_data <= w_wr_data;
                        end else begin
                            r_state  <= S_READ;
                            r_ext_rd <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (i_ext_ready) begin
                        r_rdata  <= i_ext_rd_data;
                        r_ext_rd <= 1'b0;
                        if (r_op == OP_RD) begin
                            r_state <= S_RESP;
                        end else begin
                            // set/clear: go straight into the write phase
                            r_state       <= S_WRITE;
                            r_ext_wr      <= 1'b1;
                            r_ext_wr_data <= w_rmw_data;
                            r_cnt         <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_RESP;
                        r_ext_rd <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (i_ext_ready || w_timeout) begin
                        r_state  <= S_RESP;
                        r_ext_wr <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Response registers: one-cycle ack to the owner; the other master's
    // err/rd_data keep their previous values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m0_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m0_rd_data <= '0;
            r_m1_ack     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m1_rd_data <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            if (w_fin) begin
                if (r_gnt) begin
                    r_m1_ack     <= 1'b1;
                    r_m1_err     <= w_fin_err;
                    r_m1_rd_data <= w_fin_data;
                end else begin
                    r_m0_ack     <= 1'b1;
                    r_m0_err     <= w_fin_err;
                    r_m0_rd_data <= w_fin_data;
                end
            end
        end
    end

    assign o_ext_addr    = r_ext_addr;
    assign o_ext_wr_data = r_ext_wr_data;
    assign o_ext_rd      = r_ext_rd;
    assign o_ext_wr      = r_ext_wr;
    assign o_m0_ack      = r_m0_ack;
    assign o_m0_err      = r_m0_err;
    assign o_m0_rd_data  = r_m0_rd_data;
    assign o_m1_ack      = r_m1_ack;
    assign o_m1_err      = r_m1_err;
    assign o_m1_rd_data  = r_m1_rd_data;

endmodule
